parity_frame_tx: RTL

PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

---
 rtl/parity_frame_tx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/parity_frame_tx.sv
// Serial transmitter for 11-bit frames: start(0), 8 data bits LSB first,
// caller-supplied odd-parity bit, stop(1). Each bit lasts CLKS_PER_BIT clocks.
// The supplied parity is checked against the data and flagged on par_err,
// but it is always transmitted exactly as given.
module parity_frame_tx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       parity,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       busy,
   output logic       done,
   output logic       par_err
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_idx;
   logic [7:0]    r_data;
   logic          r_par;
   logic          r_tx;
   logic          r_ready;
   logic          r_busy;
   logic          r_done;
   logic          r_par_err;

   state_t        w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [2:0]    w_idx_nxt;
   logic [7:0]    w_data_nxt;
   logic          w_par_nxt;
   logic          w_hs;
   logic          w_last;
   logic          w_tx_nxt;
   logic          w_done_nxt;
   logic          w_par_err_nxt;

   // Next-state, bit timing and next-output decode; outputs are derived from
   // the next state so they can be registered without adding a cycle of lag.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_idx_nxt     = r_idx;
      w_data_nxt    = r_data;
      w_par_nxt     = r_par;
      w_hs          = valid & r_ready;
      w_last        = (r_cnt == CNT_LAST);
      w_tx_nxt      = 1'b1;
      w_done_nxt    = 1'b0;
      w_par_err_nxt = 1'b0;

      if (r_state != IDLE) begin
         w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
      end else begin
         w_cnt_nxt = '0;
      end

      case (r_state)
         IDLE: begin
            if (w_hs) begin
               w_state_nxt   = START;
               w_data_nxt    = data;
               w_par_nxt     = parity;
               w_idx_nxt     = '0;
               w_par_err_nxt = (parity != ~(^data));
            end
         end
         START: begin
            if (w_last) begin
               w_state_nxt = DATA;
               w_idx_nxt   = '0;
            end
         end
         DATA: begin
            if (w_last) begin
               if (r_idx == 3'd7) begin
                  w_state_nxt = PARITY;
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end
         PARITY: begin
            if (w_last) w_state_nxt = STOP;
         end
         STOP: begin
            if (w_last) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase

      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = w_data_nxt[w_idx_nxt];
         PARITY:  w_tx_nxt = w_par_nxt;
         default: w_tx_nxt = 1'b1;
      endcase

      w_done_nxt = (w_state_nxt == STOP) && (w_cnt_nxt == CNT_LAST);
   end

   // State, counters, latched byte and registered outputs, with sync reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_data    <= '0;
         r_par     <= 1'b0;
         r_tx      <= 1'b1;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_par_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_idx     <= w_idx_nxt;
         r_data    <= w_data_nxt;
         r_par     <= w_par_nxt;
         r_tx      <= w_tx_nxt;
         r_ready   <= (w_state_nxt == IDLE);
         r_busy    <= (w_state_nxt != IDLE);
         r_done    <= w_done_nxt;
         r_par_err <= w_par_err_nxt;
      end
   end

   assign tx      = r_tx;
   assign ready   = r_ready;
   assign busy    = r_busy;
   assign done    = r_done;
   assign par_err = r_par_err;

endmodule
